// File: rtl/pdm_multi.sv
// pdm_multi: multi-channel PDM/PWM modulator with frame-aligned level commits.
// Writes are staged mid-frame and committed together at the frame boundary.
module pdm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 5,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                pwm_mode,
  output logic [CHANNELS-1:0] pdm_out,
  output logic [CHANNELS-1:0] pending,
  output logic                frame_strobe
);
  logic [WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0]    staging_q [CHANNELS];
  logic [WIDTH-1:0]    staging_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [WIDTH-1:0]    acc_q [CHANNELS];
  logic [WIDTH-1:0]    acc_d [CHANNELS];
  logic [WIDTH:0]      sum [CHANNELS];
  logic [CHANNELS-1:0] pending_q, pending_d, pdm_q, pdm_d, hit;
  logic                mode_q, mode_d, bnd, wr_ok, clr;
  always_comb begin
    bnd = &frame_cnt_q;
    wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(CHANNELS));
    clr = bnd && (pwm_mode != mode_q);
    frame_cnt_d = frame_cnt_q + WIDTH'(1);
    mode_d = bnd ? pwm_mode : mode_q;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = wr_ok && (wr_ch == CH_W'(c));
      sum[c] = {1'b0, acc_q[c]} + {1'b0, active_q[c]};
      staging_d[c] = (hit[c] && !bnd) ? wr_data : staging_q[c];
      pending_d[c] = bnd ? 1'b0 : (hit[c] | pending_q[c]);
      // a write landing in the boundary cycle bypasses staging entirely
      active_d[c] = !bnd ? active_q[c] : hit[c] ? wr_data : pending_q[c] ? staging_q[c] : active_q[c];
      acc_d[c] = clr ? '0 : mode_q ? acc_q[c] : sum[c][WIDTH-1:0];
      pdm_d[c] = mode_q ? (frame_cnt_q < active_q[c]) : sum[c][WIDTH];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      staging_q <= '{default: '0};
      active_q <= '{default: '0};
      acc_q <= '{default: '0};
      pending_q <= '0;
      pdm_q <= '0;
      mode_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      staging_q <= staging_d;
      active_q <= active_d;
      acc_q <= acc_d;
      pending_q <= pending_d;
      pdm_q <= pdm_d;
      mode_q <= mode_d;
    end
  end
  assign pdm_out = pdm_q;
  assign pending = pending_q;
  assign frame_strobe = (frame_cnt_q == '0);
endmodule
